voq_manager: RTL and testbench
==============================

# voq_manager

Parametrised virtual-output-queue manager for one ingress port: EGRESS_CNT independent ring-buffer FIFOs of packet metadata (first-segment control address) sharing one dual-port RAM. It supersedes the fixed 4-queue VOQ unit with full-capacity queues, per-queue occupancy, an almost-full watermark, per-queue drop counters, a registered dequeue handshake and a per-queue flush. It sits between the ingress segment writer (enqueue) and the crossbar scheduler (dequeue).

## Interface
- EGRESS_CNT, 4, number of VOQs (≥2, power of two)
- PACKET_CNT, 1024, entries per VOQ (power of two)
- META_WIDTH, 10, metadata width
- AF_THRESH, PACKET_CNT-8, almost_full asserts when occupancy ≥ this
- DROP_W, 16, drop-counter width (saturating)
- Derived: QW = $clog2(EGRESS_CNT), AW = $clog2(PACKET_CNT), CW = AW+1

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enq_valid  in  1  enqueue request
- enq_sel  in  QW  target VOQ
- enq_meta  in  META_WIDTH  metadata to store
- enq_accept  out  1  combinational: request accepted this cycle
- deq_req  in  1  dequeue request
- deq_sel  in  QW  source VOQ
- deq_valid  out  1  registered: deq_meta/deq_qid valid
- deq_meta  out  META_WIDTH  dequeued metadata
- deq_qid  out  QW  VOQ that deq_meta came from
- flush  in  1  discard all entries of flush_sel
- flush_sel  in  QW  VOQ to flush
- is_empty  out  EGRESS_CNT  per-VOQ occupancy == 0
- is_full  out  EGRESS_CNT  per-VOQ occupancy == PACKET_CNT
- almost_full  out  EGRESS_CNT  per-VOQ occupancy ≥ AF_THRESH
- occupancy  out  EGRESS_CNT*CW  packed counts, VOQ q at [q*CW +: CW]
- drop_count  out  EGRESS_CNT*DROP_W  packed per-VOQ rejected enqueues

## Operation
- Per VOQ: head (AW), tail (AW), count (CW). Pointers wrap naturally modulo PACKET_CNT; all PACKET_CNT slots usable.
- RAM address = {sel, ptr}, depth EGRESS_CNT*PACKET_CNT. Write port driven by enqueue, read port by dequeue.
- fq = flush && flush_sel == q.
- Enqueue accepted iff enq_valid && !is_full[enq_sel] && !f(enq_sel). On accept: RAM[{enq_sel,tail}] <= enq_meta, tail+1, count+1. RAM write enable is enq_accept only.
- Enqueue rejected because of full (not flush): drop_count[enq_sel] += 1, saturating at 2^DROP_W-1.
- Dequeue accepted iff deq_req && !is_empty[deq_sel] && !f(deq_sel): head+1, count−1; RAM read issued at {deq_sel,head}.
- Dequeue on empty or flushed VOQ: ignored, deq_valid stays 0 next cycle, no state change.
- Same VOQ enqueue + dequeue in one cycle: both judged on pre-edge state; if both accepted count unchanged, both pointers advance. Full VOQ: dequeue proceeds, enqueue dropped. Empty VOQ: enqueue proceeds, dequeue ignored (no same-cycle bypass).
- RAM read/write address collision cannot occur (read slot occupied, write slot free); no bypass logic required.
- Flush: head, tail, count of flush_sel ← 0; drop_count unchanged; any in-flight deq_valid from the previous cycle still completes.
- Status outputs derived combinationally from registered count.

## Timing
- Reset (async assert, sync-released internally): all head/tail/count = 0, drop_count = 0, deq_valid = 0, deq_meta = 0, deq_qid = 0. is_empty = all 1s, is_full/almost_full = 0, occupancy = 0. RAM contents not reset.
- Reset asserted mid-operation: all above take reset values immediately; an in-flight dequeue is lost.
- Enqueue accepted at edge N: is_empty/occupancy update after N; dequeue may be requested in cycle N+1.
- Dequeue latency: request accepted at edge N → deq_valid=1 with deq_meta, deq_qid during cycle N+1 (one cycle), back-to-back dequeues give one result per cycle.
- enq_accept is combinational from enq_valid, enq_sel, flush, flush_sel and registered state; no combinational path from deq_* to enq_accept.

## Structure
- Package voq_pkg: default parameter constants and DROP_W; no parameter-dependent typedefs.
- Sub-module voq_ptr (one per VOQ via generate): head/tail/count/drop counter, inputs enq_hit, deq_hit, flush_hit, drop_hit; outputs pointers, count, drop count.
- RAM: existing simple_dual_port_mem, MEM_SIZE = EGRESS_CNT*PACKET_CNT, DATA_WIDTH = META_WIDTH, registered read.

## Test plan (PACKET_CNT=4, EGRESS_CNT=4, AF_THRESH=3)
- Reset then enqueue 0x11,0x22 to VOQ2, dequeue VOQ2 twice → deq_valid next cycles with 0x11 then 0x22, deq_qid=2, is_empty[2] back to 1.
- Enqueue 5 entries to VOQ1 → accepts 4, is_full[1]=1, almost_full[1] from 3rd, 5th rejected, drop_count[1]=1, other VOQs unaffected.
- Full VOQ1 with simultaneous enqueue 0x99 + dequeue → dequeue returns oldest, enqueue dropped, occupancy 3, drop_count 2.
- Empty VOQ0 with simultaneous enqueue 0x5 + dequeue → deq_valid 0 next cycle, occupancy 1; next dequeue returns 0x5.
- Wrap: 10 alternating enq/deq cycles on VOQ3 with incrementing data → outputs in order, pointers wrap, occupancy never >1.
- Flush VOQ1 while full with concurrent enqueue to VOQ1 → occupancy 0, enq_accept 0, drop_count unchanged; async rst_n pulse mid-dequeue clears deq_valid immediately.

Source files
------------

// File: rtl/voq_pkg.sv
// ============================================================================
// voq_pkg : default sizing constants shared by the VOQ manager files
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package voq_pkg;

  localparam int VOQ_EGRESS_CNT = 4;
  localparam int VOQ_PACKET_CNT = 1024;
  localparam int VOQ_META_WIDTH = 10;
  localparam int VOQ_DROP_W     = 16;

endpackage

`default_nettype wire

// File: rtl/simple_dual_port_mem.sv
// ============================================================================
// simple_dual_port_mem : one write port, one registered read port, no reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module simple_dual_port_mem #(
  parameter int MEM_SIZE   = 1024,
  parameter int DATA_WIDTH = 10,
  localparam int AW        = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/voq_ptr.sv
// ============================================================================
// voq_ptr : head/tail/occupancy and saturating drop counter for one VOQ
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module voq_ptr
  import voq_pkg::*;
#(
  parameter int AW     = 10,
  parameter int CW     = AW + 1,
  parameter int DROP_W = VOQ_DROP_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enq_hit_i,
  input  logic              deq_hit_i,
  input  logic              flush_hit_i,
  input  logic              drop_hit_i,
  output logic [AW-1:0]     head_o,
  output logic [AW-1:0]     tail_o,
  output logic [CW-1:0]     count_o,
  output logic [DROP_W-1:0] drop_o
);

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (flush_hit_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_hit_i) tail_d = tail_q + 1'b1;
      if (deq_hit_i) head_d = head_q + 1'b1;
      if (enq_hit_i && !deq_hit_i)      count_d = count_q + 1'b1;
      else if (!enq_hit_i && deq_hit_i) count_d = count_q - 1'b1;
    end
    if (drop_hit_i && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign drop_o  = drop_q;

endmodule

`default_nettype wire

// File: rtl/voq_manager.sv
// ============================================================================
// voq_manager : EGRESS_CNT ring-buffer VOQs of packet metadata in one shared RAM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module voq_manager
  import voq_pkg::*;
#(
  parameter int EGRESS_CNT = VOQ_EGRESS_CNT,
  parameter int PACKET_CNT = VOQ_PACKET_CNT,
  parameter int META_WIDTH = VOQ_META_WIDTH,
  parameter int AF_THRESH  = PACKET_CNT - 8,
  parameter int DROP_W     = VOQ_DROP_W,
  localparam int QW        = $clog2(EGRESS_CNT),
  localparam int AW        = $clog2(PACKET_CNT),
  localparam int CW        = AW + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enq_valid_i,
  input  logic [QW-1:0]                enq_sel_i,
  input  logic [META_WIDTH-1:0]        enq_meta_i,
  output logic                         enq_accept_o,
  input  logic                         deq_req_i,
  input  logic [QW-1:0]                deq_sel_i,
  output logic                         deq_valid_o,
  output logic [META_WIDTH-1:0]        deq_meta_o,
  output logic [QW-1:0]                deq_qid_o,
  input  logic                         flush_i,
  input  logic [QW-1:0]                flush_sel_i,
  output logic [EGRESS_CNT-1:0]        is_empty_o,
  output logic [EGRESS_CNT-1:0]        is_full_o,
  output logic [EGRESS_CNT-1:0]        almost_full_o,
  output logic [EGRESS_CNT*CW-1:0]     occupancy_o,
  output logic [EGRESS_CNT*DROP_W-1:0] drop_count_o
);

  // Reset asserts asynchronously but releases two edges later on clk_i.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [AW-1:0]         head  [EGRESS_CNT];
  logic [AW-1:0]         tail  [EGRESS_CNT];
  logic [CW-1:0]         count [EGRESS_CNT];
  logic [EGRESS_CNT-1:0] empty, full;
  logic                  deq_accept;
  logic [META_WIDTH-1:0] rd_data;
  logic                  deq_valid_q;
  logic [QW-1:0]         deq_qid_q;

  assign enq_accept_o = enq_valid_i && !full[enq_sel_i]
                        && !(flush_i && (flush_sel_i == enq_sel_i));
  assign deq_accept   = deq_req_i && !empty[deq_sel_i]
                        && !(flush_i && (flush_sel_i == deq_sel_i));

  for (genvar q = 0; q < EGRESS_CNT; q++) begin : g_voq
    localparam logic [QW-1:0] QID = QW'(q);
    logic flush_hit, enq_hit, deq_hit, drop_hit;

    assign flush_hit = flush_i && (flush_sel_i == QID);
    assign enq_hit   = enq_accept_o && (enq_sel_i == QID);
    assign deq_hit   = deq_accept && (deq_sel_i == QID);
    // Only capacity rejections count as drops; flush rejections do not.
    assign drop_hit  = enq_valid_i && (enq_sel_i == QID) && full[q] && !flush_hit;

    voq_ptr #(
      .AW     (AW),
      .CW     (CW),
      .DROP_W (DROP_W)
    ) u_ptr (
      .clk_i       (clk_i),
      .rst_ni      (rst_int_n),
      .enq_hit_i   (enq_hit),
      .deq_hit_i   (deq_hit),
      .flush_hit_i (flush_hit),
      .drop_hit_i  (drop_hit),
      .head_o      (head[q]),
      .tail_o      (tail[q]),
      .count_o     (count[q]),
      .drop_o      (drop_count_o[q*DROP_W +: DROP_W])
    );

    assign empty[q]                 = (count[q] == '0);
    assign full[q]                  = (count[q] == CW'(PACKET_CNT));
    assign almost_full_o[q]         = (count[q] >= CW'(AF_THRESH));
    assign occupancy_o[q*CW +: CW]  = count[q];
  end

  simple_dual_port_mem #(
    .MEM_SIZE   (EGRESS_CNT * PACKET_CNT),
    .DATA_WIDTH (META_WIDTH)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (enq_accept_o),
    .wr_addr_i ({enq_sel_i, tail[enq_sel_i]}),
    .wr_data_i (enq_meta_i),
    .rd_en_i   (deq_accept),
    .rd_addr_i ({deq_sel_i, head[deq_sel_i]}),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      deq_valid_q <= 1'b0;
      deq_qid_q   <= '0;
    end else begin
      deq_valid_q <= deq_accept;
      if (deq_accept) deq_qid_q <= deq_sel_i;
    end
  end

  // RAM output is not reset, so gate it to keep deq_meta at zero when idle.
  assign deq_meta_o    = deq_valid_q ? rd_data : '0;
  assign deq_valid_o   = deq_valid_q;
  assign deq_qid_o     = deq_qid_q;
  assign is_empty_o    = empty;
  assign is_full_o     = full;

endmodule

`default_nettype wire

// File: tb/tb_voq_manager.sv
// ============================================================================
// tb_voq_manager : directed self-checking bench for voq_manager (4 VOQs x 4)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_voq_manager;

  localparam int EC = 4;
  localparam int PC = 4;
  localparam int MW = 10;
  localparam int DW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enq_valid, deq_req, flush;
  logic [1:0]    enq_sel, deq_sel, flush_sel;
  logic [MW-1:0] enq_meta;
  logic          enq_accept, deq_valid;
  logic [MW-1:0] deq_meta;
  logic [1:0]    deq_qid;
  logic [EC-1:0] is_empty, is_full, almost_full;
  logic [EC*CW-1:0] occupancy;
  logic [EC*DW-1:0] drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  voq_manager #(
    .EGRESS_CNT (EC),
    .PACKET_CNT (PC),
    .META_WIDTH (MW),
    .AF_THRESH  (3),
    .DROP_W     (DW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enq_valid_i   (enq_valid),
    .enq_sel_i     (enq_sel),
    .enq_meta_i    (enq_meta),
    .enq_accept_o  (enq_accept),
    .deq_req_i     (deq_req),
    .deq_sel_i     (deq_sel),
    .deq_valid_o   (deq_valid),
    .deq_meta_o    (deq_meta),
    .deq_qid_o     (deq_qid),
    .flush_i       (flush),
    .flush_sel_i   (flush_sel),
    .is_empty_o    (is_empty),
    .is_full_o     (is_full),
    .almost_full_o (almost_full),
    .occupancy_o   (occupancy),
    .drop_count_o  (drop_count)
  );

  function automatic logic [31:0] occ(input int q);
    return 32'(occupancy[q*CW +: CW]);
  endfunction

  function automatic logic [31:0] drp(input int q);
    return 32'(drop_count[q*DW +: DW]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic ev, input logic [1:0] es, input logic [MW-1:0] em,
                       input logic dr, input logic [1:0] ds,
                       input logic fl, input logic [1:0] fs);
    enq_valid = ev; enq_sel = es; enq_meta = em;
    deq_req = dr;   deq_sel = ds;
    flush = fl;     flush_sel = fs;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_empty", 32'(is_empty), 32'hF);
    chk("rst_full", 32'(is_full), 32'h0);
    chk("rst_af", 32'(almost_full), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_drop", 32'(drop_count[31:0]) | 32'(drop_count[63:32]), 32'h0);
    chk("rst_dvalid", 32'(deq_valid), 32'h0);
    chk("rst_dmeta", 32'(deq_meta), 32'h0);
    chk("rst_dqid", 32'(deq_qid), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic enqueue/dequeue on VOQ2
    drive(1'b1, 2'd2, 10'h11, 1'b0, 2'd0, 1'b0, 2'd0);
    #1 chk("t1_acc0", 32'(enq_accept), 32'h1);
    tick();
    drive(1'b1, 2'd2, 10'h22, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    chk("t1_occ2", occ(2), 32'd2);
    chk("t1_empty", 32'(is_empty), 32'hB);
    drive(1'b0, 2'd0, '0, 1'b1, 2'd2, 1'b0, 2'd0);
    tick();
    chk("t1_dv0", 32'(deq_valid), 32'h1);
    chk("t1_dm0", 32'(deq_meta), 32'h11);
    chk("t1_dq0", 32'(deq_qid), 32'h2);
    tick();
    chk("t1_dv1", 32'(deq_valid), 32'h1);
    chk("t1_dm1", 32'(deq_meta), 32'h22);
    chk("t1_empty2", 32'(is_empty), 32'hF);
    idle();
    tick();
    chk("t1_dv_idle", 32'(deq_valid), 32'h0);

    // Fill VOQ1 past capacity
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, MW'(10'hA1 + i), 1'b0, 2'd0, 1'b0, 2'd0);
      #1 chk("t2_acc", 32'(enq_accept), (i < 4) ? 32'h1 : 32'h0);
      tick();
      chk("t2_occ1", occ(1), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("t2_af1", 32'(almost_full[1]), (i >= 2) ? 32'h1 : 32'h0);
    end
    idle();
    chk("t2_full", 32'(is_full), 32'h2);
    chk("t2_drop1", drp(1), 32'd1);
    chk("t2_drop0", drp(0), 32'd0);
    chk("t2_occ2", occ(2), 32'd0);

    // Full VOQ1: simultaneous enqueue and dequeue
    drive(1'b1, 2'd1, 10'h99, 1'b1, 2'd1, 1'b0, 2'd0);
    #1 chk("t3_acc", 32'(enq_accept), 32'h0);
    tick();
    idle();
    chk("t3_dv", 32'(deq_valid), 32'h1);
    chk("t3_dm", 32'(deq_meta), 32'hA1);
    chk("t3_dq", 32'(deq_qid), 32'h1);
    chk("t3_occ1", occ(1), 32'd3);
    chk("t3_drop1", drp(1), 32'd2);
    chk("t3_full", 32'(is_full), 32'h0);

    // Empty VOQ0: simultaneous enqueue and dequeue, no bypass
    drive(1'b1, 2'd0, 10'h5, 1'b1, 2'd0, 1'b0, 2'd0);
    #1 chk("t4_acc", 32'(enq_accept), 32'h1);
    tick();
    chk("t4_dv", 32'(deq_valid), 32'h0);
    chk("t4_occ0", occ(0), 32'd1);
    drive(1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    idle();
    chk("t4_dv2", 32'(deq_valid), 32'h1);
    chk("t4_dm2", 32'(deq_meta), 32'h5);
    chk("t4_dq2", 32'(deq_qid), 32'h0);
    chk("t4_occ0b", occ(0), 32'd0);

    // Wrap VOQ3 with alternating traffic
    drive(1'b1, 2'd3, 10'h30, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 2'd3, MW'(10'h30 + i), 1'b1, 2'd3, 1'b0, 2'd0);
      tick();
      chk("t5_dv", 32'(deq_valid), 32'h1);
      chk("t5_dm", 32'(deq_meta), 32'(10'h30 + i - 1));
      chk("t5_occ3", occ(3), 32'd1);
    end
    drive(1'b0, 2'd0, '0, 1'b1, 2'd3, 1'b0, 2'd0);
    tick();
    idle();
    chk("t5_dm_last", 32'(deq_meta), 32'h39);
    chk("t5_dq_last", 32'(deq_qid), 32'h3);
    chk("t5_occ3_end", occ(3), 32'd0);

    // Flush full VOQ1 with concurrent enqueue
    drive(1'b1, 2'd1, 10'hB0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    chk("t6_full", 32'(is_full[1]), 32'h1);
    drive(1'b1, 2'd1, 10'hC0, 1'b0, 2'd0, 1'b1, 2'd1);
    #1 chk("t6_acc", 32'(enq_accept), 32'h0);
    tick();
    idle();
    chk("t6_occ1", occ(1), 32'd0);
    chk("t6_drop1", drp(1), 32'd2);
    chk("t6_empty", 32'(is_empty), 32'hF);

    // In-flight dequeue completes across a flush; flushed dequeue is ignored
    drive(1'b1, 2'd1, 10'hD0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    drive(1'b1, 2'd1, 10'hD1, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    drive(1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b0, 2'd0);
    tick();
    drive(1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b1, 2'd1);
    chk("t6_dv_inflight", 32'(deq_valid), 32'h1);
    chk("t6_dm_inflight", 32'(deq_meta), 32'hD0);
    tick();
    idle();
    chk("t6_dv_flushed", 32'(deq_valid), 32'h0);
    chk("t6_occ1b", occ(1), 32'd0);

    // Asynchronous reset mid-dequeue
    drive(1'b1, 2'd2, 10'hE0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    drive(1'b0, 2'd0, '0, 1'b1, 2'd2, 1'b0, 2'd0);
    tick();
    idle();
    chk("t7_dv_pre", 32'(deq_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_dv_rst", 32'(deq_valid), 32'h0);
    chk("t7_dm_rst", 32'(deq_meta), 32'h0);
    chk("t7_drop_rst", drp(1), 32'd0);
    chk("t7_empty_rst", 32'(is_empty), 32'hF);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    drive(1'b1, 2'd0, 10'h7, 1'b0, 2'd0, 1'b0, 2'd0);
    #1 chk("t7_acc", 32'(enq_accept), 32'h1);
    tick();
    idle();
    chk("t7_occ0", occ(0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
